imm_encoder: RTL and testbench

- Inverse of the datapath's immediate extension: takes a signed 32-bit immediate, a format select and an instruction template, and packs the immediate bits into the RV32I I/S/B/J field positions.
- Checks that the immediate is representable in the chosen format; flags and counts violations.
- 2-stage valid/ready pipeline. Sits between the test-program generator / boot loader and instruction memory.

---
 rtl/imm_encoder.sv | 100 ++++++++++
 tb/tb_imm_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs a signed 32-bit immediate into the RV32I I/S/B/J field positions of an
// instruction template, flagging immediates that do not fit the chosen format.
module imm_encoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [1:0]       in_src,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_t;

  typedef struct packed {
    logic [31:0] imm;
    fmt_t        src;
    logic [31:0] base;
  } s1_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic        s1_valid;
  s1_t         s1;
  logic        adv;
  logic [31:0] enc_instr;
  logic        enc_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;

  // Encode from the stage-1 register so stage 2 only has to capture the result.
  always_comb begin
    enc_instr = s1.base;
    enc_err   = 1'b0;
    unique case (s1.src)
      FMT_I: begin
        enc_instr[31:20] = s1.imm[11:0];
        enc_err          = !(&s1.imm[31:11] || ~|s1.imm[31:11]);
      end
      FMT_S: begin
        enc_instr[31:25] = s1.imm[11:5];
        enc_instr[11:7]  = s1.imm[4:0];
        enc_err          = !(&s1.imm[31:11] || ~|s1.imm[31:11]);
      end
      FMT_B: begin
        {enc_instr[31], enc_instr[7], enc_instr[30:25], enc_instr[11:8]} =
          {s1.imm[12], s1.imm[11], s1.imm[10:5], s1.imm[4:1]};
        enc_err = !(&s1.imm[31:12] || ~|s1.imm[31:12]) || s1.imm[0];
      end
      FMT_J: begin
        {enc_instr[31], enc_instr[19:12], enc_instr[20], enc_instr[30:21]} =
          {s1.imm[20], s1.imm[19:12], s1.imm[11], s1.imm[10:1]};
        enc_err = !(&s1.imm[31:20] || ~|s1.imm[31:20]) || s1.imm[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1.imm   <= in_imm;
      s1.src   <= fmt_t'(in_src);
      s1.base  <= in_base;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (out_valid && out_ready && out_err && err_count != ERR_MAX)
        err_count <= err_count + ERR_W'(1);
      // Data only moves on a load so a stalled word stays stable.
      if (adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= enc_instr;
          out_err   <= enc_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: randomized beats checked against a field-map
// reference model, plus a second ERR_W=2 instance for counter saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_imm, in_base, out_instr;
  logic [1:0]  in_src;
  logic [7:0]  err_count;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_err_count;

  imm_encoder #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count));

  imm_encoder #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_err(s_out_err), .err_count(s_err_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] base;
    bit          has_exp;
    logic [31:0] exp_instr;
    bit          exp_err;
  } stim_t;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] instr;
    bit          err;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    nchk = 0, nerr = 0;
  int    cyc = 0, acc_cyc = 0, acc_cnt = 0, dlv_cnt = 0, model_cnt = 0;
  int    ready_mode = 1;  // 0 stall, 1 always ready, 2 random
  bit    loaded = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: which immediate bit lands in each instruction bit position.
  function automatic int map_bit(input logic [1:0] src, input int pos);
    int r;
    r = -1;
    case (src)
      2'd0: if (pos >= 20) r = pos - 20;
      2'd1: begin
        if (pos >= 25) r = pos - 20;
        else if (pos >= 7 && pos <= 11) r = pos - 7;
      end
      2'd2: begin
        if (pos == 31) r = 12;
        else if (pos >= 25) r = pos - 20;
        else if (pos >= 8 && pos <= 11) r = pos - 7;
        else if (pos == 7) r = 11;
      end
      default: begin
        if (pos == 31) r = 20;
        else if (pos >= 21) r = pos - 20;
        else if (pos == 20) r = 11;
        else if (pos >= 12) r = pos;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_pack(input logic [31:0] imm, input logic [1:0] src,
                                             input logic [31:0] base);
    logic [31:0] r;
    int b;
    r = base;
    for (int p = 0; p < 32; p++) begin
      b = map_bit(src, p);
      if (b >= 0) r[p] = imm[b];
    end
    return r;
  endfunction

  function automatic bit model_err(input logic [31:0] imm, input logic [1:0] src);
    longint v;
    v = longint'($signed(imm));
    case (src)
      2'd0, 2'd1: return !(v >= -2048 && v <= 2047);
      2'd2:       return !(v >= -4096 && v <= 4095 && (v % 2) == 0);
      default:    return !(v >= -(64'sd1 << 20) && v < (64'sd1 << 20) && (v % 2) == 0);
    endcase
  endfunction

  // Datapath-style immediate extraction, used for the round-trip property.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [1:0] src);
    case (src)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_legal(input logic [1:0] s);
    int v;
    case (s)
      2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
      2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      default:    v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
    endcase
    return v;
  endfunction

  task automatic push_model(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base);
    stim_t s;
    s.imm = imm; s.src = src; s.base = base; s.has_exp = 0; s.exp_instr = '0; s.exp_err = 0;
    stim_q.push_back(s);
  endtask

  task automatic push_exp(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base,
                          input logic [31:0] ei, input bit ee);
    stim_t s;
    s.imm = imm; s.src = src; s.base = base; s.has_exp = 1; s.exp_instr = ei; s.exp_err = ee;
    stim_q.push_back(s);
  endtask

  // Driver: presents stimulus and records the expected word on each accept.
  initial begin
    stim_t cur;
    exp_t  e;
    in_valid = 0; in_imm = '0; in_src = '0; in_base = '0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (reset) begin
        in_valid = 0;
        loaded   = 0;
        continue;
      end
      if (!loaded && stim_q.size() > 0) begin
        cur    = stim_q.pop_front();
        loaded = 1;
      end
      in_valid = loaded;
      if (loaded) begin
        in_imm = cur.imm; in_src = cur.src; in_base = cur.base;
      end
      #1;
      if (in_valid && in_ready) begin
        e.imm = cur.imm; e.src = cur.src;
        e.instr = cur.has_exp ? cur.exp_instr : model_pack(cur.imm, cur.src, cur.base);
        e.err   = cur.has_exp ? cur.exp_err   : model_err(cur.imm, cur.src);
        sb_q.push_back(e);
        loaded  = 0;
        acc_cnt++;
        acc_cyc = cyc;
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 0;
        1:       out_ready = 1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t        e;
    bit          stall;
    logic [31:0] held_i;
    logic        held_e;
    int          cap;
    stall = 0; held_i = '0; held_e = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stall = 0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_word", {out_instr[31:1], out_instr[0] ^ out_err}, {held_i[31:1], held_i[0] ^ held_e});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          if (!e.err) chk("round_trip", decode(out_instr, e.src), e.imm);
          cap = (model_cnt > 255) ? 255 : model_cnt;
          chk("err_count", 32'(err_count), 32'(cap));
          cap = (model_cnt > 3) ? 3 : model_cnt;
          chk("err_count_sat", 32'(s_err_count), 32'(cap));
          if (e.err) model_cnt++;
          dlv_cnt++;
        end
      end
      stall  = out_valid && !out_ready;
      held_i = out_instr;
      held_e = out_err;
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #3;
      if (stim_q.size() == 0 && !loaded && sb_q.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 32'(sb_q.size() + stim_q.size()), 32'd0);
  endtask

  initial begin
    int a0, d0, lat;
    logic [1:0] s;
    reset = 1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 0;

    // First beat also measures accept-to-valid latency.
    ready_mode = 1;
    @(negedge clk); #3;
    push_exp(32'hFFFF_FFFF, 2'd0, 32'h0000_0013, 32'hFFF0_0013, 0);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(negedge clk); #3;
    end
    lat = cyc - acc_cyc;
    chk("latency", 32'(lat), 32'd2);
    wait_idle(50);

    push_exp(32'd8,          2'd2, 32'h0000_0063, 32'h0000_0463, 0);
    push_exp(32'd3,          2'd2, 32'h0000_0063, 32'h0000_0163, 1);
    push_exp(32'hFFFF_FFFC,  2'd3, 32'h0000_006F, 32'hFFDF_F06F, 0);
    push_exp(32'd2048,       2'd1, 32'h0000_2023, 32'h8000_2023, 1);
    wait_idle(50);
    chk("directed_err_count", 32'(err_count), 32'd2);

    // Backpressure: downstream stalled for three cycles.
    @(negedge clk); #3;
    ready_mode = 0;
    a0 = acc_cnt; d0 = dlv_cnt;
    for (int i = 0; i < 4; i++) push_model(32'(i * 4), 2'd0, 32'h0000_0013 + 32'(i << 7));
    repeat (3) @(negedge clk);
    #3;
    chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 1;
    wait_idle(50);
    chk("bp_delivered", 32'(dlv_cnt - d0), 32'd4);

    // Reset in the middle of a stream.
    ready_mode = 2;
    for (int i = 0; i < 8; i++) push_model(32'd1 + 32'(i), 2'd2, 32'h0000_0063);
    repeat (4) @(negedge clk);
    #3;
    reset = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_err_count_sat", 32'(s_err_count), 32'd0);
    stim_q.delete();
    sb_q.delete();
    model_cnt = 0;
    @(negedge clk); #3;
    reset = 0;

    // Saturation of the narrow counter.
    ready_mode = 1;
    for (int i = 0; i < 5; i++) push_model(32'(2 * i + 1), 2'd2, 32'h0000_0063);
    wait_idle(50);
    chk("sat_err_count", 32'(s_err_count), 32'd3);
    chk("wide_err_count", 32'(err_count), 32'd5);

    // Random legal round-trips over all formats, random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      s = 2'($urandom_range(0, 3));
      push_model(rand_legal(s), s, $urandom());
    end
    wait_idle(60000);

    // Unconstrained immediates exercise the range checks.
    for (int i = 0; i < 200; i++) begin
      s = 2'($urandom_range(0, 3));
      push_model((i % 2 == 0) ? $urandom() : rand_legal(s) + 32'($urandom_range(0, 1)), s, $urandom());
    end
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
